// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU requester: opcodes, response status,
// FSM states and the packed response word held in the response buffer.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_ILLEGAL = 2'b10
   } status_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      GAP
   } state_e;

   localparam int DEF_TIMEOUT_CYCLES = 15;
   localparam int DEF_RSP_DEPTH      = 2;
   localparam int RSP_W              = 21;

   typedef struct packed {
      logic [15:0] result;
      logic [2:0]  op;
      status_e     status;
   } rsp_t;

   // Only add/and/xor/mul are forwarded to the ALU.
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op != 3'(OP_NOP)) && (op <= 3'(OP_MUL));
   endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response buffer: power-of-two deep FIFO with combinational head output.
// Storage is cleared on reset so the head fields read zero while in reset.
module alu_rsp_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = RSP_W,
   parameter int DEPTH = DEF_RSP_DEPTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic [AW:0]                 count;
   logic                        do_push;
   logic                        do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign do_push = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_requester.sv
// Issues commands to a handshake ALU, bounds each request with a timeout and
// queues one response per accepted command, including no_op and illegal ops.
module alu_requester
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int RSP_DEPTH      = DEF_RSP_DEPTH
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic [7:0]  alu_A,
   output logic [7:0]  alu_B,
   output logic [2:0]  alu_op,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic [1:0]  rsp_status
);

   state_e             state;
   state_e             next_state;
   logic [7:0]         wait_cnt;
   logic               accept;
   logic               accept_alu;
   logic               timeout;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   rsp_t               push_rsp;
   rsp_t               head_rsp;
   logic [RSP_W-1:0]   head_bits;

   assign accept     = cmd_valid && cmd_ready;
   assign accept_alu = accept && is_alu_op(cmd_op);
   // wait_cnt holds the start cycles already elapsed, so this is the last allowed one.
   assign timeout    = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
   assign alu_start  = (state == BUSY);

   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      push       = 1'b0;
      push_rsp   = '0;
      case (state)
         IDLE: begin
            // Admission reserves a buffer slot, so the later ALU push cannot overflow.
            cmd_ready = !fifo_full;
            if (accept) begin
               if (is_alu_op(cmd_op)) begin
                  next_state = BUSY;
               end else begin
                  push            = 1'b1;
                  push_rsp.result = 16'h0000;
                  push_rsp.op     = cmd_op;
                  push_rsp.status = (cmd_op == 3'(OP_NOP)) ? ST_OK : ST_ILLEGAL;
               end
            end
         end
         BUSY: begin
            if (alu_done) begin
               push            = 1'b1;
               push_rsp.result = alu_result;
               push_rsp.op     = alu_op;
               push_rsp.status = ST_OK;
               next_state      = GAP;
            end else if (timeout) begin
               push            = 1'b1;
               push_rsp.result = 16'h0000;
               push_rsp.op     = alu_op;
               push_rsp.status = ST_TIMEOUT;
               next_state      = GAP;
            end
         end
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
         alu_A    <= 8'd0;
         alu_B    <= 8'd0;
         alu_op   <= 3'd0;
      end else begin
         state <= next_state;
         if (state == BUSY && next_state == BUSY)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;
         // Operands only move on ALU-op acceptance and are frozen through BUSY.
         if (accept_alu) begin
            alu_A  <= cmd_a;
            alu_B  <= cmd_b;
            alu_op <= cmd_op;
         end
      end
   end

   assign pop = rsp_valid && rsp_ready;

   alu_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_rsp),
      .pop       (pop),
      .pop_data  (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_rsp   = rsp_t'(head_bits);
   assign rsp_valid  = !fifo_empty;
   assign rsp_result = head_rsp.result;
   assign rsp_op     = head_rsp.op;
   assign rsp_status = head_rsp.status;

endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- TIMEOUT_CYCLES, 15, max cycles alu_start is held awaiting alu_done (range 4..255).
- RSP_DEPTH, 2, response buffer entries (power of 2, >=2).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- reset_n, in, 1, reset, asynchronous, active-low.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when both are high at an edge.
- cmd_op, in, 3, operation: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101-111 illegal.
- cmd_a, in, 8, operand A.
- cmd_b, in, 8, operand B.
- alu_A, out, 8, operand A to the ALU.
- alu_B, out, 8, operand B to the ALU.
- alu_op, out, 3, opcode to the ALU.
- alu_start, out, 1, request to the ALU; held until alu_done or timeout.
- alu_done, in, 1, one-cycle completion pulse from the ALU.
- alu_result, in, 16, ALU result, valid in the alu_done cycle.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed when both are high at an edge.
- rsp_result, out, 16, response result.
- rsp_op, out, 3, opcode of the response.
- rsp_status, out, 2, 00 ok, 01 timeout, 10 illegal op.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and GAP.
REQ-004 In IDLE, cmd_ready SHALL be 1 iff the response buffer has at least one free entry; in BUSY and GAP it SHALL be 0.
REQ-005 On acceptance of add/and/xor/mul, the block SHALL register cmd_a/cmd_b/cmd_op onto alu_A/alu_B/alu_op, assert alu_start from the next cycle, and enter BUSY.
REQ-006 alu_A, alu_B and alu_op SHALL be stable for the whole of BUSY.
REQ-007 On acceptance of no_op, the block SHALL push {result 16'h0000, status 00} without asserting alu_start and stay in IDLE.
REQ-008 On acceptance of an illegal op, the block SHALL push {result 16'h0000, status 10} without asserting alu_start and stay in IDLE.
REQ-009 In BUSY, when alu_done=1 the block SHALL push {alu_result, status 00}, deassert alu_start on the next edge and enter GAP.
REQ-010 In BUSY, the 8-bit wait counter SHALL count cycles with alu_start=1.
REQ-011 When the wait counter reaches TIMEOUT_CYCLES with no alu_done, the block SHALL push {16'h0000, status 01}, deassert alu_start and enter GAP.
REQ-012 If alu_done and timeout occur in the same cycle, alu_done SHALL win and status SHALL be 00.
REQ-013 GAP SHALL last exactly one cycle with alu_start=0, then go to IDLE; back-to-back ALU requests are therefore separated by at least one idle cycle.
REQ-014 alu_done received in IDLE or GAP SHALL be ignored; nothing is pushed.
REQ-015 The response buffer SHALL be FIFO-ordered; rsp_valid = not empty, and rsp_* SHALL show the head entry.
REQ-016 A push and a pop in the same cycle SHALL both occur with the occupancy unchanged.
REQ-017 Read and write pointers SHALL wrap modulo RSP_DEPTH.
REQ-018 A push SHALL never be lost: admission per REQ-004 reserves the entry before any ALU issue.
REQ-019 rsp_valid SHALL rise the cycle after a push into an empty buffer.
REQ-020 Latency from the acceptance edge to rsp_valid SHALL be 1 cycle for no_op/illegal ops and (alu_done cycle + 1) for ALU ops.

Reset
REQ-021 While reset_n=0, alu_start, rsp_valid, alu_A, alu_B, alu_op, rsp_result, rsp_op, rsp_status and the wait counter SHALL all be 0.
REQ-022 While reset_n=0, the FSM SHALL be in IDLE and the buffer SHALL be empty.
REQ-023 Reset asserted mid-operation SHALL immediately drop alu_start and discard all buffered responses.
REQ-024 cmd_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-025 Shared package alu_pkg SHALL hold the opcode enum, the status enum (OK, TIMEOUT, ILLEGAL), the FSM state enum and the default constants.
REQ-026 The response buffer SHALL be the sub-module alu_rsp_fifo, of width 21 bits (result + op + status) and depth RSP_DEPTH.

Verification
REQ-027 add A=8'h05 B=8'h03, responder done after 1 cycle -> rsp_result 16'h0008, rsp_op 001, status 00.
REQ-028 mul A=8'hFF B=8'hFF, responder done 3 cycles after start -> rsp_result 16'hFE01, alu_start high exactly 4 cycles, then 1 GAP cycle.
REQ-029 xor with responder silent -> alu_start drops after 15 cycles; rsp_result 16'h0000, status 01; a late alu_done is ignored.
REQ-030 rsp_ready=0, three no_op commands -> two accepted, cmd_ready=0 until one pop, then the third is accepted; responses arrive in order.
REQ-031 op 3'b111 -> status 10, alu_start never asserted.
REQ-032 Reset pulse during BUSY of a mul -> alu_start=0 and rsp_valid=0 immediately; a new add after release completes correctly.
